// File: rtl/count_seg_display.sv
// count_seg_display
// Converts an N-bit unsigned count into up to four BCD digits with a
// sequential shift-and-add-3 converter, then time-multiplexes those digits
// onto a common-anode seven-segment display. Leading zeros are blanked,
// while the ones digit is always lit. All outputs are decoded from registers
// only, so the display never sees a half-converted value.
module count_seg_display #(
  parameter int N           = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] count,
  output logic [6:0]   seg,
  output logic [3:0]   an,
  output logic         dp,
  output logic         busy
);

  // Width of the refresh prescaler and its terminal value.
  localparam int SW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(REFRESH_DIV - 1);

  // The shift counter runs 0..N-1. N is at most 13, so four bits suffice.
  localparam logic [3:0] SHIFT_LAST = 4'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  src_q, src_d;
  logic [N-1:0]  work_q, work_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [15:0]   disp_q, disp_d;
  logic          force_q, force_d;
  logic [3:0]    shiftCnt_q, shiftCnt_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    digit_q, digit_d;

  logic [15:0]   bcdAdj;
  logic [3:0]    curNibble;
  logic          curBlank;

  // Add 3 to every BCD nibble that is 5 or more, so that the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [15:0] addThree(input logic [15:0] v);
    logic [15:0] r;
    logic [3:0]  nib;
    r = v;
    for (int i = 0; i < 4; i++) begin
      nib = v[4*i +: 4];
      if (nib >= 4'd5) begin
        r[4*i +: 4] = nib + 4'd3;
      end
    end
    return r;
  endfunction

  // Map a BCD nibble to active-low segments in g..a order. Values 10..15
  // cannot occur, so they blank all segments.
  function automatic logic [6:0] segDecode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Converter state. The force flag makes the first cycle after reset
  // start a conversion even if count happens to be zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      work_q     <= '0;
      bcd_q      <= '0;
      disp_q     <= '0;
      force_q    <= 1'b1;
      shiftCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      work_q     <= work_d;
      bcd_q      <= bcd_d;
      disp_q     <= disp_d;
      force_q    <= force_d;
      shiftCnt_q <= shiftCnt_d;
    end
  end

  // Capture, shift N times, then latch the result into the display copy.
  // src_q stays untouched while converting and acts as the "last value
  // converted" reference. work_q is the copy that is shifted out.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    work_d     = work_q;
    bcd_d      = bcd_q;
    disp_d     = disp_q;
    force_d    = force_q;
    shiftCnt_d = shiftCnt_q;
    bcdAdj     = addThree(bcd_q);
    case (state_q)
      IDLE: begin
        if ((count != src_q) || force_q) begin
          src_d      = count;
          work_d     = count;
          bcd_d      = '0;
          force_d    = 1'b0;
          shiftCnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d      = {bcdAdj[14:0], work_q[N-1]};
        work_d     = work_q << 1;
        shiftCnt_d = shiftCnt_q + 4'd1;
        if (shiftCnt_q == SHIFT_LAST) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Refresh prescaler and digit index. These run freely, independent of
  // the converter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q  <= '0;
      digit_q <= '0;
    end else begin
      scan_q  <= scan_d;
      digit_q <= digit_d;
    end
  end

  // Wrap the prescaler at REFRESH_DIV-1 and step to the next digit slot.
  always_comb begin
    scan_d  = scan_q + 1'b1;
    digit_d = digit_q;
    if (scan_q == SCAN_LAST) begin
      scan_d  = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  // Select the nibble for the current slot. A digit is blanked when it and
  // every more significant digit are zero. The ones digit is never blanked.
  always_comb begin
    curNibble = disp_q[3:0];
    curBlank  = 1'b0;
    case (digit_q)
      2'd0: begin
        curNibble = disp_q[3:0];
        curBlank  = 1'b0;
      end
      2'd1: begin
        curNibble = disp_q[7:4];
        curBlank  = (disp_q[15:4] == 12'd0);
      end
      2'd2: begin
        curNibble = disp_q[11:8];
        curBlank  = (disp_q[15:8] == 8'd0);
      end
      default: begin
        curNibble = disp_q[15:12];
        curBlank  = (disp_q[15:12] == 4'd0);
      end
    endcase
  end

  // Drive the display pins from registered state only.
  always_comb begin
    seg  = segDecode(curNibble);
    an   = curBlank ? 4'b1111 : ~(4'b0001 << digit_q);
    dp   = 1'b1;
    busy = (state_q != IDLE);
  end

endmodule

// File: tb/tb_count_seg_display.sv
// tb_count_seg_display
// Directed test of count_seg_display. Three instances share one clock and
// one reset: N=4, N=8 and N=13, all with a 4-cycle refresh slot. After each
// reset release, t counts clock edges. The digit slot at edge t is
// (t/4)%4.
module tb_count_seg_display;

  logic        clk;
  logic        reset;
  logic [3:0]  count4;
  logic [7:0]  count8;
  logic [12:0] count13;

  logic [6:0]  seg4, seg8, seg13;
  logic [3:0]  an4, an8, an13;
  logic        dp4, dp8, dp13;
  logic        busy4, busy8, busy13;

  int checkCount;
  int passCount;
  int t;

  count_seg_display #(.N(4), .REFRESH_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .count(count4),
    .seg(seg4), .an(an4), .dp(dp4), .busy(busy4)
  );

  count_seg_display #(.N(8), .REFRESH_DIV(4)) dut8 (
    .clk(clk), .reset(reset), .count(count8),
    .seg(seg8), .an(an8), .dp(dp8), .busy(busy8)
  );

  count_seg_display #(.N(13), .REFRESH_DIV(4)) dut13 (
    .clk(clk), .reset(reset), .count(count13),
    .seg(seg13), .an(an13), .dp(dp13), .busy(busy13)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
  endtask

  // Advance to edge number target after the last reset release, then settle
  // 1 time unit past that edge.
  task automatic advanceTo(input int target);
    while (t < target) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  // Set the N=4 instance's count input.
  task automatic applyStimulus(input logic [3:0] c4);
    count4 = c4;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    t          = 0;
    reset      = 1'b1;
    count4     = 4'd0;
    count8     = 8'd100;
    count13    = 13'd8191;
    #2 reset   = 1'b0;
    #1;

    // Reset values.
    checkOutput("rst_an4",   16'(an4),   16'b1110);
    checkOutput("rst_seg4",  16'(seg4),  16'b1000000);
    checkOutput("rst_dp4",   16'(dp4),   16'd1);
    checkOutput("rst_busy4", 16'(busy4), 16'd0);
    checkOutput("rst_an13",  16'(an13),  16'b1110);
    checkOutput("rst_busy13",16'(busy13),16'd0);

    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    t = 0;

    // Forced conversion after release, busy for N+1 cycles.
    advanceTo(1);
    checkOutput("first_busy4",  16'(busy4),  16'd1);
    checkOutput("first_busy8",  16'(busy8),  16'd1);
    checkOutput("first_busy13", 16'(busy13), 16'd1);
    advanceTo(3);
    checkOutput("zero_an4",  16'(an4),  16'b1110);
    checkOutput("zero_seg4", 16'(seg4), 16'b1000000);
    advanceTo(5);
    checkOutput("zero_busy4_last", 16'(busy4), 16'd1);
    advanceTo(6);
    checkOutput("zero_busy4_done", 16'(busy4), 16'd0);
    checkOutput("zero_blank1_an4", 16'(an4),   16'b1111);
    advanceTo(9);
    checkOutput("busy8_last", 16'(busy8), 16'd1);
    advanceTo(10);
    checkOutput("busy8_done", 16'(busy8), 16'd0);
    advanceTo(14);
    checkOutput("busy13_last", 16'(busy13), 16'd1);
    advanceTo(15);
    checkOutput("busy13_done", 16'(busy13), 16'd0);

    // Scan through all four slots: 8191, 100 and 0.
    advanceTo(17);
    checkOutput("d0_an13",  16'(an13),  16'b1110);
    checkOutput("d0_seg13", 16'(seg13), 16'b1111001);
    checkOutput("d0_an8",   16'(an8),   16'b1110);
    checkOutput("d0_seg8",  16'(seg8),  16'b1000000);
    checkOutput("d0_dp13",  16'(dp13),  16'd1);
    advanceTo(21);
    checkOutput("d1_an13",  16'(an13),  16'b1101);
    checkOutput("d1_seg13", 16'(seg13), 16'b0010000);
    checkOutput("d1_an8",   16'(an8),   16'b1101);
    checkOutput("d1_seg8",  16'(seg8),  16'b1000000);
    checkOutput("d1_an4",   16'(an4),   16'b1111);
    advanceTo(25);
    checkOutput("d2_an13",  16'(an13),  16'b1011);
    checkOutput("d2_seg13", 16'(seg13), 16'b1111001);
    checkOutput("d2_an8",   16'(an8),   16'b1011);
    checkOutput("d2_seg8",  16'(seg8),  16'b1111001);
    advanceTo(29);
    checkOutput("d3_an13",  16'(an13),  16'b0111);
    checkOutput("d3_seg13", 16'(seg13), 16'b0000000);
    checkOutput("d3_an8",   16'(an8),   16'b1111);
    checkOutput("d3_dp8",   16'(dp8),   16'd1);

    // N=4 shows 7. Capture at 30, latch at 35.
    applyStimulus(4'd7);
    advanceTo(30);
    checkOutput("seven_busy_start", 16'(busy4), 16'd1);
    advanceTo(35);
    checkOutput("seven_busy_done",  16'(busy4), 16'd0);
    advanceTo(37);
    checkOutput("seven_d1_an", 16'(an4), 16'b1111);
    advanceTo(41);
    checkOutput("seven_d2_an", 16'(an4), 16'b1111);
    advanceTo(45);
    checkOutput("seven_d3_an", 16'(an4), 16'b1111);
    advanceTo(49);
    checkOutput("seven_d0_an",  16'(an4),  16'b1110);
    checkOutput("seven_d0_seg", 16'(seg4), 16'b1111000);

    // 5 then 9 one cycle after capture. Capture k=59, 5 shown at 64,
    // 9 captured at 65, latched at 70.
    advanceTo(58);
    applyStimulus(4'd5);
    advanceTo(59);
    checkOutput("five_capture_busy", 16'(busy4), 16'd1);
    applyStimulus(4'd9);
    advanceTo(63);
    checkOutput("five_latch_busy", 16'(busy4), 16'd1);
    advanceTo(64);
    checkOutput("five_idle_busy", 16'(busy4), 16'd0);
    checkOutput("five_seg",       16'(seg4),  16'b0010010);
    checkOutput("five_an",        16'(an4),   16'b1110);
    advanceTo(65);
    checkOutput("nine_capture_busy", 16'(busy4), 16'd1);
    advanceTo(67);
    checkOutput("five_still_seg", 16'(seg4), 16'b0010010);
    advanceTo(69);
    checkOutput("nine_latch_busy", 16'(busy4), 16'd1);
    advanceTo(70);
    checkOutput("nine_done_busy", 16'(busy4), 16'd0);
    advanceTo(80);
    checkOutput("nine_seg", 16'(seg4), 16'b0010000);

    // Convert 0, then start 9 and reset during its 2nd SHIFT cycle.
    applyStimulus(4'd0);
    advanceTo(86);
    applyStimulus(4'd9);
    advanceTo(88);
    checkOutput("abort_pre_busy", 16'(busy4), 16'd1);
    checkOutput("abort_pre_an",   16'(an4),   16'b1111);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", 16'(busy4), 16'd0);
    checkOutput("abort_an",   16'(an4),   16'b1110);
    checkOutput("abort_seg",  16'(seg4),  16'b1000000);
    checkOutput("abort_dp",   16'(dp4),   16'd1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    t = 0;

    // After release, 9 is converted again. There is no partial value
    // before the latch.
    advanceTo(1);
    checkOutput("reconv_busy_start", 16'(busy4), 16'd1);
    advanceTo(3);
    checkOutput("reconv_no_partial", 16'(seg4), 16'b1000000);
    advanceTo(5);
    checkOutput("reconv_busy_last", 16'(busy4), 16'd1);
    advanceTo(6);
    checkOutput("reconv_busy_done", 16'(busy4), 16'd0);
    checkOutput("reconv_d1_blank",  16'(an4),   16'b1111);
    advanceTo(17);
    checkOutput("reconv_an",  16'(an4),  16'b1110);
    checkOutput("reconv_seg", 16'(seg4), 16'b0010000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
